// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit beside the EX-stage ALU.
// Owns the architectural HI/LO registers. It executes mult/multu/div/divu
// with a fixed latency and services mthi/mtlo in a single cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous reset, active low
//   A      rs operand (dividend / multiplicand / mthi-mtlo source)
//   B      rt operand (divisor / multiplier)
//   MDop   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   start  qualifies MDop for one cycle
//   busy   operation in flight (registered)
//   HI/LO  architectural HI/LO registers (registered)
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDop,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     pend;     // {hi, lo} committed when the countdown ends
  logic                   pend_wr;  // cleared for divide-by-zero: HI/LO keep old values

  // Full-width products; operands are extended to 2*WIDTH so the
  // low 2*WIDTH bits of the product are exact in both signednesses.
  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic        [2*WIDTH-1:0] a_zx, b_zx, prod_u;

  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_s = a_sx * b_sx;
  assign a_zx   = {{WIDTH{1'b0}}, A};
  assign b_zx   = {{WIDTH{1'b0}}, B};
  assign prod_u = a_zx * b_zx;

  // Divider operands: a zero divisor and the signed overflow case are
  // replaced by 1 so the arithmetic never sees an undefined division;
  // both cases are resolved separately below.
  logic                    b_zero, div_ovf;
  logic        [WIDTH-1:0] b_safe;
  logic signed [WIDTH-1:0] as, bs, q_s, r_s;
  logic        [WIDTH-1:0] q_u, r_u;

  assign b_zero  = (B == '0);
  assign div_ovf = (A == MOST_NEG) && (B == '1);
  assign b_safe  = (b_zero || div_ovf) ? WIDTH'(1) : B;
  assign as      = A;
  assign bs      = b_safe;
  assign q_s     = as / bs;   // truncates toward zero
  assign r_s     = as % bs;   // sign follows the dividend
  assign q_u     = A / b_safe;
  assign r_u     = A % b_safe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (MDop)
              OP_MULT: begin
                pend    <= prod_s;
                pend_wr <= 1'b1;
                cnt     <= MULT_LD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MULTU: begin
                pend    <= prod_u;
                pend_wr <= 1'b1;
                cnt     <= MULT_LD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIV: begin
                pend    <= div_ovf ? {{WIDTH{1'b0}}, A} : {r_s, q_s};
                pend_wr <= !b_zero;
                cnt     <= DIV_LD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIVU: begin
                pend    <= {r_u, q_u};
                pend_wr <= !b_zero;
                cnt     <= DIV_LD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here; the hazard unit never issues one.
          if (cnt == '0) begin
            if (pend_wr) begin
              HI <= pend[2*WIDTH-1:WIDTH];
              LO <= pend[WIDTH-1:0];
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: walks each operation through its full
// latency, checking busy and HI/LO every cycle against hand-computed values.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDop;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  int vectors = 0;
  int errs    = 0;

  // Bench-side copy of what HI/LO should hold.
  logic [31:0] m_hi, m_lo;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDop(MDop),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns just after the capturing edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDop = op; start = 1'b1;
    tick();
    start = 1'b0; MDop = 3'd0;
  endtask

  // Issue a multi-cycle op; busy must be high and HI/LO frozen for n cycles,
  // then busy low with the new result visible.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    issue(op, a, b);
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hold_hi"}, HI, m_hi);
      chk({tag, "_hold_lo"}, LO, m_lo);
      if (i == 2) begin
        A = 32'h5555_5555; B = 32'h3; // operand changes mid-run must not matter
      end
      tick();
    end
    m_hi = ehi; m_lo = elo;
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    reset = 1'b0; A = '0; B = '0; MDop = '0; start = 1'b0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    run_op("mult",  3'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    run_op("div_pos", 3'd3, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2);

    // mthi/mtlo then divide by zero: HI/LO survive the full-length run.
    issue(3'd5, 32'h1234, 32'h0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    issue(3'd6, 32'h5678, 32'h0);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_hi_kept", HI, 32'h1234);
    m_hi = 32'h1234; m_lo = 32'h5678;
    run_op("divu0", 3'd4, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    run_op("div0",  3'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

    // MDop 0 and 7 with start: no effect.
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", HI, 32'h1234);
    chk("nop_lo", LO, 32'h5678);

    issue(3'd5, 32'hAAAA, 32'h0);
    chk("mthi2_hi", HI, 32'hAAAA);
    chk("mthi2_busy", {31'd0, busy}, 32'd0);

    // Starts while busy are dropped: mult 5*6 must win.
    issue(3'd1, 32'd5, 32'd6);                 // after edge t
    A = 32'hDEAD; MDop = 3'd6; start = 1'b1;   // mtlo during run
    tick();                                    // after t+1
    A = 32'd2; B = 32'd2; MDop = 3'd1;         // second mult during run
    tick();                                    // after t+2
    start = 1'b0; MDop = 3'd0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    chk("ign_lo_hold", LO, 32'h5678);
    chk("ign_hi_hold", HI, 32'hAAAA);
    tick(); tick(); tick();                    // after t+5
    chk("ign_done_busy", {31'd0, busy}, 32'd0);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'h1E);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("ign_no_second_busy", {31'd0, busy}, 32'd0);
    chk("ign_no_second_lo", LO, 32'h1E);

    // Async reset during a div in cycle 4, then no stale writeback.
    issue(3'd3, 32'd100, 32'd7);               // in cycle t+1
    tick(); tick(); tick();                    // in cycle t+4
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_hi", HI, 32'h0);
      chk("post_rst_lo", LO, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
